// File: rtl/judge_pkg.sv
// Shared types and score weights for the hit_judge block.
// Optional build macro used by the block: GHOST_PENALTY_EN.
package judge_pkg;

    typedef enum logic [1:0] {
        G_NONE,
        G_PERFECT,
        G_GOOD,
        G_MISS
    } grade_t;

    localparam int unsigned PTS_PERFECT = 3;
    localparam int unsigned PTS_GOOD    = 1;

endpackage

// File: rtl/hit_judge_if.sv
// Keypress/arrow inputs and grading/score outputs of hit_judge.
// master: chart sequencer + key edge detectors side; slave: the judge.
interface hit_judge_if #(
    parameter int unsigned LANES   = 4,
    parameter int unsigned SCORE_W = 16,
    parameter int unsigned COMBO_W = 8
);
    logic [LANES-1:0]   arrow_due;
    logic [LANES-1:0]   keypress;
    logic [LANES-1:0]   hit_perfect;
    logic [LANES-1:0]   hit_good;
    logic [LANES-1:0]   miss;
    logic [SCORE_W-1:0] score;
    logic [COMBO_W-1:0] combo;
    logic [COMBO_W-1:0] best_combo;

    modport master (
        output arrow_due, keypress,
        input  hit_perfect, hit_good, miss, score, combo, best_combo
    );

    modport slave (
        input  arrow_due, keypress,
        output hit_perfect, hit_good, miss, score, combo, best_combo
    );
endinterface

// File: rtl/judge_lane.sv
// One lane's timing window: IDLE/OPEN FSM plus offset counter.
// The grade is decided combinationally in the input cycle; the top registers it.
// GHOST_PENALTY_EN: a press with no open window and no arrow grades MISS.
module judge_lane
    import judge_pkg::*;
#(
    parameter int unsigned WINDOW  = 16,
    parameter int unsigned PERFECT = 4
) (
    input  logic   clk,
    input  logic   reset_n,
    input  logic   arrow_due,
    input  logic   keypress,
    output grade_t grade
);

    localparam int unsigned OFF_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam logic [OFF_W-1:0] LAST_OFF = OFF_W'(WINDOW - 1);
    localparam logic [OFF_W-1:0] PERF_OFF = OFF_W'(PERFECT);

    typedef enum logic {
        S_IDLE,
        S_OPEN
    } lane_state_t;

    lane_state_t      state;
    // Offset of the current cycle relative to arrow_due; the arrow_due cycle
    // itself is offset 0, so the first OPEN cycle is loaded with 1.
    logic [OFF_W-1:0] offset;

    // Grade decision for this cycle's inputs
    always_comb begin
        grade = G_NONE;
        case (state)
            S_IDLE: begin
                if (arrow_due && keypress) begin
                    grade = G_PERFECT;
                end
`ifdef GHOST_PENALTY_EN
                else if (keypress) begin
                    grade = G_MISS;
                end
`endif
            end
            S_OPEN: begin
                if (keypress) begin
                    grade = (offset < PERF_OFF) ? G_PERFECT : G_GOOD;
                end else if (arrow_due || offset == LAST_OFF) begin
                    grade = G_MISS;
                end
            end
            default: grade = G_NONE;
        endcase
    end

    // Window state and offset counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= S_IDLE;
            offset <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (arrow_due && !keypress) begin
                        state  <= S_OPEN;
                        offset <= OFF_W'(1);
                    end
                end
                S_OPEN: begin
                    if (arrow_due) begin
                        offset <= OFF_W'(1);
                    end else if (keypress || offset == LAST_OFF) begin
                        state  <= S_IDLE;
                        offset <= '0;
                    end else begin
                        offset <= offset + OFF_W'(1);
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    offset <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/hit_judge.sv
// Multi-lane hit judge: per-lane grading, registered grade pulses and
// saturating score / combo / best_combo accumulation.
// Optional build macro: GHOST_PENALTY_EN (ghost presses count as misses).
module hit_judge
    import judge_pkg::*;
#(
    parameter int unsigned LANES   = 4,
    parameter int unsigned WINDOW  = 16,
    parameter int unsigned PERFECT = 4,
    parameter int unsigned SCORE_W = 16,
    parameter int unsigned COMBO_W = 8
) (
    input logic        clk,
    input logic        reset_n,
    hit_judge_if.slave bus
);

    localparam int unsigned ADD_W = $clog2(PTS_PERFECT * LANES + 1);
    localparam int unsigned HIT_W = $clog2(LANES + 1);

    grade_t             lane_grade [LANES];
    logic [ADD_W-1:0]   pts;
    logic [HIT_W-1:0]   hits;
    logic               any_miss;
    logic [SCORE_W:0]   score_sum;
    logic [COMBO_W:0]   combo_sum;
    logic [SCORE_W-1:0] score_next;
    logic [COMBO_W-1:0] combo_next;

    logic [LANES-1:0]   hit_perfect_q;
    logic [LANES-1:0]   hit_good_q;
    logic [LANES-1:0]   miss_q;
    logic [SCORE_W-1:0] score_q;
    logic [COMBO_W-1:0] combo_q;
    logic [COMBO_W-1:0] best_q;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        judge_lane #(
            .WINDOW  (WINDOW),
            .PERFECT (PERFECT)
        ) u_lane (
            .clk       (clk),
            .reset_n   (reset_n),
            .arrow_due (bus.arrow_due[g]),
            .keypress  (bus.keypress[g]),
            .grade     (lane_grade[g])
        );
    end

    // Sum this cycle's grades across lanes and form saturated next values
    always_comb begin
        pts      = '0;
        hits     = '0;
        any_miss = 1'b0;
        for (int unsigned i = 0; i < LANES; i++) begin
            case (lane_grade[i])
                G_PERFECT: begin
                    pts  = pts + ADD_W'(PTS_PERFECT);
                    hits = hits + HIT_W'(1);
                end
                G_GOOD: begin
                    pts  = pts + ADD_W'(PTS_GOOD);
                    hits = hits + HIT_W'(1);
                end
                G_MISS:  any_miss = 1'b1;
                default: ;
            endcase
        end
        score_sum  = {1'b0, score_q} + (SCORE_W + 1)'(pts);
        combo_sum  = {1'b0, combo_q} + (COMBO_W + 1)'(hits);
        score_next = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
        if (any_miss) begin
            combo_next = '0;
        end else begin
            combo_next = combo_sum[COMBO_W] ? '1 : combo_sum[COMBO_W-1:0];
        end
    end

    // Grade pulses and accumulators, one cycle after the deciding inputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hit_perfect_q <= '0;
            hit_good_q    <= '0;
            miss_q        <= '0;
            score_q       <= '0;
            combo_q       <= '0;
            best_q        <= '0;
        end else begin
            for (int unsigned i = 0; i < LANES; i++) begin
                hit_perfect_q[i] <= (lane_grade[i] == G_PERFECT);
                hit_good_q[i]    <= (lane_grade[i] == G_GOOD);
                miss_q[i]        <= (lane_grade[i] == G_MISS);
            end
            score_q <= score_next;
            combo_q <= combo_next;
            if (combo_next > best_q) begin
                best_q <= combo_next;
            end
        end
    end

    assign bus.hit_perfect = hit_perfect_q;
    assign bus.hit_good    = hit_good_q;
    assign bus.miss        = miss_q;
    assign bus.score       = score_q;
    assign bus.combo       = combo_q;
    assign bus.best_combo  = best_q;

endmodule

// File: tb/tb_hit_judge.sv
// Directed bench for hit_judge with a timestamp-based reference model.
`timescale 1ns/1ps
module tb_hit_judge;
    import judge_pkg::*;

    localparam int unsigned LANES   = 4;
    localparam int unsigned WINDOW  = 16;
    localparam int unsigned PERFECT = 4;
    localparam int unsigned SCORE_W = 16;
    localparam int unsigned COMBO_W = 8;
    localparam int unsigned SCORE_MAX = (1 << SCORE_W) - 1;
    localparam int unsigned COMBO_MAX = (1 << COMBO_W) - 1;

    logic clk = 1'b0;
    logic reset_n;
    bit   run_cmp;
    int   n_total = 0;
    int   n_pass  = 0;

    hit_judge_if #(.LANES(LANES), .SCORE_W(SCORE_W), .COMBO_W(COMBO_W)) bus ();

    hit_judge #(
        .LANES   (LANES),
        .WINDOW  (WINDOW),
        .PERFECT (PERFECT),
        .SCORE_W (SCORE_W),
        .COMBO_W (COMBO_W)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: each lane remembers the cycle its pending arrow arrived
    // and grades presses by elapsed cycles.
    bit               pend   [LANES];
    int unsigned      due_at [LANES];
    int unsigned      cyc;
    int unsigned      exp_score, exp_combo, exp_best;
    logic [LANES-1:0] exp_p, exp_g, exp_m;

    initial forever begin
        @(posedge clk or negedge reset_n);
        if (!reset_n) begin
            for (int l = 0; l < LANES; l++) begin pend[l] = 0; due_at[l] = 0; end
            cyc = 0; exp_score = 0; exp_combo = 0; exp_best = 0;
            exp_p = '0; exp_g = '0; exp_m = '0;
        end else begin
            logic [LANES-1:0] p, g, m, due, key;
            int unsigned age, sum;
            due = bus.arrow_due; key = bus.keypress;
            p = '0; g = '0; m = '0;
            for (int l = 0; l < LANES; l++) begin
                age = cyc - due_at[l];
                if (pend[l]) begin
                    if (key[l]) begin
                        if (age < PERFECT) p[l] = 1'b1; else g[l] = 1'b1;
                        pend[l] = 0;
                    end else if (due[l] || age == WINDOW - 1) begin
                        m[l] = 1'b1;
                        pend[l] = 0;
                    end
                    if (due[l]) begin pend[l] = 1; due_at[l] = cyc; end
                end else if (due[l]) begin
                    if (key[l]) p[l] = 1'b1;
                    else begin pend[l] = 1; due_at[l] = cyc; end
                end else if (key[l]) begin
`ifdef GHOST_PENALTY_EN
                    m[l] = 1'b1;
`endif
                end
            end
            sum = exp_score + 3 * $countones(p) + $countones(g);
            exp_score = (sum > SCORE_MAX) ? SCORE_MAX : sum;
            if (|m) exp_combo = 0;
            else begin
                sum = exp_combo + $countones(p | g);
                exp_combo = (sum > COMBO_MAX) ? COMBO_MAX : sum;
            end
            if (exp_combo > exp_best) exp_best = exp_combo;
            exp_p = p; exp_g = g; exp_m = m;
            cyc++;
        end
    end

    // Every-cycle comparison against the model
    initial forever begin
        @(negedge clk);
        if (run_cmp && reset_n) begin
            check("cyc_perfect", 32'(bus.hit_perfect), 32'(exp_p));
            check("cyc_good",    32'(bus.hit_good),    32'(exp_g));
            check("cyc_miss",    32'(bus.miss),        32'(exp_m));
            check("cyc_score",   32'(bus.score),       exp_score);
            check("cyc_combo",   32'(bus.combo),       exp_combo);
            check("cyc_best",    32'(bus.best_combo),  exp_best);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic drive(input logic [LANES-1:0] due, input logic [LANES-1:0] key);
        bus.arrow_due = due;
        bus.keypress  = key;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive('0, '0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_perfect"}, 32'(bus.hit_perfect), 0);
        check({tag, "_good"},    32'(bus.hit_good),    0);
        check({tag, "_miss"},    32'(bus.miss),        0);
        check({tag, "_score"},   32'(bus.score),       0);
        check({tag, "_combo"},   32'(bus.combo),       0);
        check({tag, "_best"},    32'(bus.best_combo),  0);
    endtask

    initial begin
        reset_n = 1'b0;
        run_cmp = 0;
        bus.arrow_due = '0;
        bus.keypress  = '0;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        reset_n = 1'b1;
        run_cmp = 1;
        idle(1);

        // Lane 0: press two cycles after arrival -> PERFECT
        drive(4'b0001, 4'b0000);
        idle(1);
        drive(4'b0000, 4'b0001);
        check("s1_perfect", 32'(bus.hit_perfect), 32'h1);
        check("s1_score",   32'(bus.score), 3);
        check("s1_combo",   32'(bus.combo), 1);
        idle(1);
        check("s1_pulse_off", 32'(bus.hit_perfect), 0);

        // Lane 1: press at offset 15 -> GOOD
        drive(4'b0010, 4'b0000);
        idle(14);
        drive(4'b0000, 4'b0010);
        check("s2_good",  32'(bus.hit_good), 32'h2);
        check("s2_score", 32'(bus.score), 4);
        check("s2_combo", 32'(bus.combo), 2);
        // Lane 1: no press -> MISS right after offset 15
        drive(4'b0010, 4'b0000);
        idle(14);
        check("s2_no_early_miss", 32'(bus.miss), 0);
        idle(1);
        check("s2_miss",  32'(bus.miss), 32'h2);
        check("s2_combo0", 32'(bus.combo), 0);
        check("s2_best",  32'(bus.best_combo), 2);

        // Lanes 0 and 2 perfect together, then miss + good together
        drive(4'b0101, 4'b0101);
        check("s3_dual_perfect", 32'(bus.hit_perfect), 32'h5);
        check("s3_score", 32'(bus.score), 10);
        check("s3_combo", 32'(bus.combo), 2);
        drive(4'b0101, 4'b0000);
        idle(14);
        drive(4'b0000, 4'b0100);
        check("s3_miss",  32'(bus.miss), 32'h1);
        check("s3_good",  32'(bus.hit_good), 32'h4);
        check("s3_score2", 32'(bus.score), 11);
        check("s3_combo0", 32'(bus.combo), 0);

        // Lane 3: second arrow 5 cycles later replaces the first
        drive(4'b1000, 4'b0000);
        idle(4);
        drive(4'b1000, 4'b0000);
        check("s4_miss",  32'(bus.miss), 32'h8);
        drive(4'b0000, 4'b1000);
        check("s4_perfect", 32'(bus.hit_perfect), 32'h8);
        check("s4_score", 32'(bus.score), 14);
        check("s4_combo", 32'(bus.combo), 1);

        // Build combo to 5, then ghost press on lane 2
        drive(4'b1111, 4'b1111);
        check("s5_score", 32'(bus.score), 26);
        check("s5_combo", 32'(bus.combo), 5);
        drive(4'b0000, 4'b0100);
`ifdef GHOST_PENALTY_EN
        check("ghost_miss",  32'(bus.miss), 32'h4);
        check("ghost_combo", 32'(bus.combo), 0);
`else
        check("ghost_miss",  32'(bus.miss), 0);
        check("ghost_combo", 32'(bus.combo), 5);
`endif
        check("ghost_score", 32'(bus.score), 26);
        check("ghost_best",  32'(bus.best_combo), 5);

        // Press and new arrow together while open: old graded, new window opens
        drive(4'b0001, 4'b0000);
        idle(1);
        drive(4'b0001, 4'b0001);
        check("s6_perfect", 32'(bus.hit_perfect), 32'h1);
        idle(14);
        check("s6_no_early_miss", 32'(bus.miss), 0);
        idle(1);
        check("s6_miss", 32'(bus.miss), 32'h1);

        // Saturation: 0x5556 perfects
        for (int i = 0; i < 32'h5556; i++) drive(4'b0001, 4'b0001);
        check("sat_score", 32'(bus.score), 32'hFFFF);
        check("sat_combo", 32'(bus.combo), 32'hFF);
        check("sat_best",  32'(bus.best_combo), 32'hFF);

        // Reset in the middle of an open window
        drive(4'b0010, 4'b0000);
        idle(1);
        #2 reset_n = 1'b0;
        #1 check_all_zero("midrst");
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2 reset_n = 1'b1;
        idle(20);
        check("post_rst_miss",  32'(bus.miss), 0);
        check("post_rst_score", 32'(bus.score), 0);
        check("post_rst_best",  32'(bus.best_combo), 0);

        run_cmp = 0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
